// File: rtl/smag_addsub_pipe.sv
// Pipelined sign-magnitude ADD/SUB for MIX words with accumulator operand and sticky
// overflow toggle; valid/ready on input and output so downstream stalls back-pressure.
module smag_addsub_pipe #(
  parameter int MAG_W   = 30,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W:0]   a,
  input  logic [MAG_W:0]   b,
  input  logic             op,
  input  logic             acc_use,
  input  logic             acc_wr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   result,
  output logic             ovf,
  output logic [MAG_W:0]   acc,
  output logic             ovf_toggle,
  input  logic             ovf_clr
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its payload steady until then, and ready never waits on valid.

  logic [LATENCY-1:0] st_valid;
  logic [LATENCY-1:0] st_ovf;
  logic [LATENCY-1:0] st_accwr;
  logic [MAG_W:0]     st_res [LATENCY];
  logic [LATENCY-1:0] ld;

  logic               sa;
  logic               sb;
  logic [MAG_W-1:0]   ma;
  logic [MAG_W-1:0]   mb;
  logic [MAG_W:0]     sum;
  logic [MAG_W:0]     a_eff;
  logic [MAG_W:0]     calc_res;
  logic               calc_ovf;
  logic               acc_pend;
  logic               accept;
  logic               out_hs;
  logic               all_full;

  // Stage-1 arithmetic; equal magnitudes of opposite sign give zero with A's sign.
  always_comb begin
    a_eff    = acc_use ? acc : a;
    sa       = a_eff[MAG_W];
    sb       = b[MAG_W] ^ op;
    ma       = a_eff[MAG_W-1:0];
    mb       = b[MAG_W-1:0];
    sum      = {1'b0, ma} + {1'b0, mb};
    calc_res = '0;
    calc_ovf = 1'b0;
    if (sa == sb) begin
      calc_res = {sa, sum[MAG_W-1:0]};
      calc_ovf = sum[MAG_W];
    end else if (ma >= mb) begin
      calc_res = {sa, ma - mb};
    end else begin
      calc_res = {sb, mb - ma};
    end
  end

  // A stage may load when it, or any stage downstream of it, has room to move.
  always_comb begin
    all_full = 1'b1;
    ld       = '0;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      all_full = all_full & st_valid[k];
      ld[k]    = out_ready | ~all_full;
    end
  end

  assign acc_pend  = |(st_valid & st_accwr);
  assign in_ready  = ld[0] & ~(acc_use & acc_pend);
  assign accept    = in_valid & in_ready;
  assign out_valid = st_valid[LATENCY-1];
  assign result    = st_res[LATENCY-1];
  assign ovf       = st_ovf[LATENCY-1];
  assign out_hs    = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      st_ovf   <= '0;
      st_accwr <= '0;
      for (int k = 0; k < LATENCY; k++) st_res[k] <= '0;
    end else begin
      if (ld[0]) begin
        st_valid[0] <= accept;
        st_res[0]   <= calc_res;
        st_ovf[0]   <= calc_ovf;
        st_accwr[0] <= acc_wr;
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (ld[k]) begin
          st_valid[k] <= st_valid[k-1];
          st_res[k]   <= st_res[k-1];
          st_ovf[k]   <= st_ovf[k-1];
          st_accwr[k] <= st_accwr[k-1];
        end
      end
    end
  end

  // Accumulator and toggle commit only when a result leaves, so a reset discards
  // in-flight work without partial side effects; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      ovf_toggle <= 1'b0;
    end else begin
      if (out_hs && st_accwr[LATENCY-1]) acc <= result;
      if (out_hs && ovf)                 ovf_toggle <= 1'b1;
      else if (ovf_clr)                  ovf_toggle <= 1'b0;
    end
  end

endmodule

// File: tb/tb_smag_addsub_pipe.sv
// Directed and random bench for smag_addsub_pipe against a transaction-level model
// (signed arithmetic with MIX sign rules, an expected-result queue and a modelled acc).
module tb_smag_addsub_pipe;
  localparam int MAG_W = 30;
  localparam int LAT   = 2;
  localparam int W     = MAG_W + 1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         acc_use;
  logic         acc_wr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         ovf;
  logic [W-1:0] acc;
  logic         ovf_toggle;
  logic         ovf_clr;

  smag_addsub_pipe #(.MAG_W(MAG_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_use(acc_use), .acc_wr(acc_wr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf),
    .acc(acc), .ovf_toggle(ovf_toggle), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [W:0]   exp_q[$];
  int           cyc_q[$];
  bit           accwr_q[$];
  logic [W-1:0] m_acc;
  logic         m_tog;
  logic [W-1:0] last_res;
  logic         last_ovf;
  int           last_lat;
  bit           accepted;

  // Returns {ovf, sign, magnitude} from the MIX sign-magnitude rules.
  function automatic logic [W:0] ref_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sub);
    longint ma, mb, s, lim;
    logic   sx, sy;
    lim = longint'(1) << MAG_W;
    sx  = x[MAG_W];
    sy  = y[MAG_W] ^ sub;
    ma  = longint'(x[MAG_W-1:0]);
    mb  = longint'(y[MAG_W-1:0]);
    if (sx == sy) begin
      s = ma + mb;
      return {s >= lim, sx, MAG_W'(s % lim)};
    end else if (ma >= mb) begin
      return {1'b0, sx, MAG_W'(ma - mb)};
    end else begin
      return {1'b0, sy, MAG_W'(mb - ma)};
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic monitor();
    logic [W:0] e;
    logic [W:0] popped;
    int         pend;
    bit         exp_rdy;
    bit         hs;
    accepted = 0;
    if (!rst_n) return;
    chk("acc", acc, m_acc);
    chk("ovf_toggle", ovf_toggle, m_tog);
    pend = 0;
    foreach (accwr_q[i]) if (accwr_q[i]) pend++;
    exp_rdy = (out_ready || exp_q.size() < LAT) && !(acc_use && pend > 0);
    chk("in_ready", in_ready, exp_rdy);
    e = '0;
    if (in_valid && in_ready) e = ref_calc(acc_use ? m_acc : a, b, op);
    hs = 0;
    popped = '0;
    if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 1'b0);
      else begin
        chk("result", {ovf, result}, exp_q[0]);
        hs = out_ready;
      end
    end
    if (hs) begin
      popped   = exp_q.pop_front();
      last_lat = cyc - cyc_q.pop_front();
      last_res = popped[W-1:0];
      last_ovf = popped[W];
      if (accwr_q.pop_front()) m_acc = popped[W-1:0];
    end
    if (hs && popped[W]) m_tog = 1'b1;
    else if (ovf_clr)    m_tog = 1'b0;
    if (in_valid && in_ready) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc);
      accwr_q.push_back(acc_wr);
      accepted = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    acc_use  = 1'b0;
    acc_wr   = 1'b0;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                        input logic au, input logic aw);
    a = x; b = y; op = o; acc_use = au; acc_wr = aw; in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (accepted) break;
    end
    chk("accept_timeout", accepted, 1'b1);
    drain();
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [MAG_W-1:0] m;
    case ($urandom_range(0, 4))
      0:       m = '0;
      1:       m = '1;
      2:       m = MAG_W'(1);
      default: m = MAG_W'($urandom);
    endcase
    return {1'($urandom_range(0, 1)), m};
  endfunction

  localparam logic [W-1:0] POS5   = 31'h00000005;
  localparam logic [W-1:0] NEG5   = 31'h40000005;
  localparam logic [W-1:0] MAXP   = 31'h3FFFFFFF;
  localparam logic [W-1:0] MAXN   = 31'h7FFFFFFF;
  localparam logic [W-1:0] NEG2   = 31'h40000002;
  localparam logic [W-1:0] NEG_Z  = 31'h40000000;

  logic [W-1:0] ta [4];
  logic [W-1:0] tbv[4];
  int           idx;
  int           stall;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; acc_use = 1'b0;
    acc_wr = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    m_acc = '0; m_tog = 1'b0; last_res = '0; last_ovf = 1'b0; last_lat = 0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_acc", acc, '0);
    chk("rst_toggle", ovf_toggle, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Zero sign rules
    run_op(POS5, NEG5, 1'b0, 1'b0, 1'b0);
    chk("pos5_add_neg5", last_res, 31'h00000000);
    run_op(NEG5, POS5, 1'b0, 1'b0, 1'b0);
    chk("neg5_add_pos5", last_res, NEG_Z);
    run_op(POS5, POS5, 1'b1, 1'b0, 1'b0);
    chk("pos5_sub_pos5", last_res, 31'h00000000);

    // Overflow wrap and toggle
    run_op(MAXP, 31'h1, 1'b0, 1'b0, 1'b0);
    chk("ovf_pos_res", last_res, 31'h00000000);
    chk("ovf_pos_flag", last_ovf, 1'b1);
    chk("ovf_toggle_set", ovf_toggle, 1'b1);
    run_op(MAXN, NEG2, 1'b0, 1'b0, 1'b0);
    chk("ovf_neg_res", last_res, 31'h40000001);
    chk("ovf_neg_flag", last_ovf, 1'b1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("toggle_cleared", ovf_toggle, 1'b0);

    // Back-pressure: four back-to-back ops with the consumer stalled for three cycles
    ta[0] = 31'h5;        tbv[0] = 31'h6;
    ta[1] = 31'h40000003; tbv[1] = 31'h1;
    ta[2] = MAXP;         tbv[2] = 31'h1;
    ta[3] = 31'h9;        tbv[3] = 31'h40000004;
    idx = 0; op = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 40 && (idx < 4 || exp_q.size() != 0); c++) begin
      if (c == 3) chk("accepted_during_stall", idx, 2);
      out_ready = (c >= 3);
      in_valid  = (idx < 4);
      if (idx < 4) begin a = ta[idx]; b = tbv[idx]; end
      tick();
      if (accepted) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_issued", idx, 4);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_last_res", last_res, 31'h5);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

    // Accumulator interlock
    a = 31'h7; b = 31'h0; op = 1'b0; acc_use = 1'b0; acc_wr = 1'b1; in_valid = 1'b1;
    tick();
    chk("op1_accepted", accepted, 1'b1);
    a = 31'h0; b = 31'h3; acc_use = 1'b1; acc_wr = 1'b1;
    stall = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (accepted) break;
      stall++;
    end
    chk("interlock_stall", stall, LAT);
    chk("acc_after_op1", acc, 31'h7);
    drain();
    chk("acc_op2_res", last_res, 31'hA);
    chk("acc_after_op2", acc, 31'hA);

    // Toggle race: clear in the same cycle as an overflowing handshake
    out_ready = 1'b0; a = MAXP; b = 31'h1; op = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    chk("race_out_valid", out_valid, 1'b1);
    out_ready = 1'b1; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("race_toggle_kept", ovf_toggle, 1'b1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("race_toggle_clr", ovf_toggle, 1'b0);

    // Reset with two operations in flight
    run_op(MAXP, 31'h1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; a = 31'h1; b = 31'h2;
    tick();
    a = 31'h3; b = 31'h4;
    tick();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_acc", acc, '0);
    chk("mid_rst_toggle", ovf_toggle, 1'b0);
    exp_q.delete(); cyc_q.delete(); accwr_q.delete();
    m_acc = '0; m_tog = 1'b0;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); cyc++; #1;
    run_op(31'd100, 31'h4000001E, 1'b1, 1'b0, 1'b0);
    chk("post_rst_res", last_res, 31'd130);
    chk("post_rst_latency", last_lat, LAT);

    // Random traffic
    in_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a        = rnd_word();
        b        = rnd_word();
        op       = 1'($urandom_range(0, 1));
        acc_use  = ($urandom_range(0, 3) == 0);
        acc_wr   = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      ovf_clr   = ($urandom_range(0, 9) == 0);
      tick();
    end
    out_ready = 1'b1; ovf_clr = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
